// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0) used for IF/ID bubbles.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned     DEFAULT_QDEPTH   = 2;

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN - 2){1'b1}}, 2'b00};

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } fetch_state_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus: valid/grant request, in-order response.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; any depth, not only powers of two.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pop from empty is ignored; push into full only when a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and count update; flush discards contents and same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, bounded outstanding fetches, redirect
// handling with response killing, and the IF/ID pipeline register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     QDEPTH   = DEFAULT_QDEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush_IF_ID,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    fetch_if.master         imem,
    output logic            IF_ID_valid,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instr,
    output logic [4:0]      IF_ID_rs1_addr,
    output logic [4:0]      IF_ID_rs2_addr
);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e    state_q, state_d;
    logic            run;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            accept;

    logic [XLEN-1:0] tag_pc;
    logic            tag_full, tag_empty;
    logic [CNT_W-1:0] tag_count;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic            resp_valid, resp_killed, resp_live;

    fetch_entry_t    dq_wdata, dq_rdata;
    logic            dq_push, dq_pop;
    logic            dq_full, dq_empty;
    logic [CNT_W-1:0] dq_count;
    logic [OCC_W-1:0] occupancy;

    ifid_t           ifid_q, ifid_d;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: BOOT lasts exactly one cycle, RUN is permanent.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // FSM outputs: fetching is only permitted in RUN.
    always_comb begin
        run = 1'b0;
        unique case (state_q)
            StBoot:  run = 1'b0;
            StRun:   run = 1'b1;
            default: run = 1'b0;
        endcase
    end

    // In-flight tags plus queued instructions never exceed QDEPTH, which is
    // what keeps the data queue from overflowing while IF/ID is stalled.
    assign occupancy = {1'b0, tag_count} + {1'b0, dq_count};

    assign imem.imem_req  = run && (occupancy < OCC_W'(QDEPTH)) && !tag_full && !dq_full;
    assign imem.imem_addr = pc_q;
    assign accept         = imem.imem_req && imem.imem_gnt;

    // PC update: redirect wins; a grant in the redirect cycle used the old PC.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = word_align(branch_target);
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Address tags of outstanding requests, popped in order by responses.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (accept),
        .wdata (pc_q),
        .pop   (imem.imem_rvalid),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // A response with no tag outstanding (e.g. one issued before reset) is ignored.
    assign resp_valid  = imem.imem_rvalid && !tag_empty;
    // The kill bit of each tag is kept as a count of the oldest tags that are
    // killed: a redirect marks every tag alive after this edge.
    assign resp_killed = (kill_cnt_q != '0);
    assign resp_live   = resp_valid && !resp_killed;

    // Kill count: a redirect kills all tags, including one pushed this cycle.
    always_comb begin
        kill_cnt_d = kill_cnt_q;
        if (branch_taken) begin
            kill_cnt_d = tag_count + CNT_W'(accept) - CNT_W'(resp_valid);
        end else if (resp_valid && resp_killed) begin
            kill_cnt_d = kill_cnt_q - CNT_W'(1);
        end
    end

    // Kill count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            kill_cnt_q <= '0;
        end else begin
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign dq_wdata = '{pc: tag_pc, instr: imem.imem_rdata};

    // Instructions that arrived while IF/ID could not take them.
    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_data_queue (
        .clk   (clk),
        .reset (reset),
        .flush (branch_taken),
        .push  (dq_push),
        .wdata (dq_wdata),
        .pop   (dq_pop),
        .rdata (dq_rdata),
        .full  (dq_full),
        .empty (dq_empty),
        .count (dq_count)
    );

    // IF/ID next state and queue steering; priority redirect > flush > stall.
    always_comb begin
        ifid_d  = ifid_q;
        dq_push = 1'b0;
        dq_pop  = 1'b0;
        if (branch_taken) begin
            ifid_d = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
        end else if (flush_IF_ID) begin
            ifid_d  = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
            dq_push = resp_live;
        end else if (stall) begin
            dq_push = resp_live;
        end else if (!dq_empty) begin
            ifid_d  = '{valid: 1'b1, pc: dq_rdata.pc, instr: dq_rdata.instr};
            dq_pop  = 1'b1;
            dq_push = resp_live;
        end else if (resp_live) begin
            ifid_d = '{valid: 1'b1, pc: tag_pc, instr: imem.imem_rdata};
        end else begin
            ifid_d = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSTR};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign IF_ID_valid    = ifid_q.valid;
    assign IF_ID_pc       = ifid_q.pc;
    assign IF_ID_instr    = ifid_q.instr;
    assign IF_ID_rs1_addr = ifid_q.instr[19:15];
    assign IF_ID_rs2_addr = ifid_q.instr[24:20];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL expose parameter QDEPTH, default 2, meaning the maximum number of in-flight plus queued fetches.
REQ-003 Ports SHALL be:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  synchronous, active-high
  stall  in  1  hazard-unit stall: hold PC-visible IF/ID contents
  flush_IF_ID  in  1  hazard-unit flush: IF/ID becomes bubble
  branch_taken  in  1  resolved taken branch from EX/MEM (redirect)
  branch_target  in  32  redirect address
  imem_req  out  1  fetch request valid
  imem_addr  out  32  fetch address (word aligned)
  imem_gnt  in  1  request accepted when imem_req && imem_gnt
  imem_rvalid  in  1  in-order response valid, ≥1 cycle after grant
  imem_rdata  in  32  instruction word
  IF_ID_valid  out  1  IF/ID holds a real instruction
  IF_ID_pc  out  32  PC of IF/ID instruction
  IF_ID_instr  out  32  instruction, NOP when invalid
  IF_ID_rs1_addr  out  5  IF_ID_instr[19:15]
  IF_ID_rs2_addr  out  5  IF_ID_instr[24:20]

Function
REQ-004 The fetch PC register SHALL drive imem_addr and SHALL advance by 4 (mod 2^32) on each accepted request.
REQ-005 imem_req SHALL be high only in state RUN and when (in-flight count + queued count) < QDEPTH.
REQ-006 Each accepted request SHALL push {pc, kill=0} into a tag FIFO of depth QDEPTH; each imem_rvalid SHALL pop one tag.
REQ-007 A popped response with kill=1 SHALL be discarded; otherwise {tag.pc, imem_rdata} SHALL go to IF/ID (bypass) or to the data queue.
REQ-008 Bypass: when data queue empty, stall=0, flush/redirect absent, a valid response SHALL load IF/ID on the next edge (rvalid-to-IF_ID_valid latency 1 cycle).
REQ-009 With stall=0 and queue non-empty, IF/ID SHALL load the queue head (oldest first) and any live response SHALL be enqueued.
REQ-010 With stall=0 and no instruction available, IF/ID SHALL become a bubble (IF_ID_valid=0, IF_ID_instr=32'h0000_0013, IF_ID_pc unchanged).
REQ-011 With stall=1, IF/ID SHALL hold all fields; live responses SHALL be enqueued; the queue SHALL never overflow (guaranteed by REQ-005).
REQ-012 flush_IF_ID=1 SHALL make IF/ID a bubble on the next edge, overriding stall; queue content SHALL be kept unless branch_taken.
REQ-013 branch_taken=1 SHALL, on the next edge: load PC with branch_target, set kill on every valid tag including one pushed that cycle, empty the data queue, make IF/ID a bubble; priority over stall.
REQ-014 A request granted in the redirect cycle SHALL use the old PC and be killed.
REQ-015 FSM states: BOOT (after reset, imem_req=0, one cycle) -> RUN; RUN permanent until reset.
REQ-016 branch_target SHALL be used as given; bits [1:0] SHALL be forced to 0 on load.

Reset
REQ-017 On reset: PC=RESET_PC, state=BOOT, tag FIFO and data queue empty, counters 0, IF_ID_valid=0, IF_ID_instr=32'h0000_0013, IF_ID_pc=RESET_PC, imem_req=0.
REQ-018 Reset mid-operation SHALL also discard every outstanding response; responses arriving after reset with empty tag FIFO SHALL be ignored.

Structure
REQ-019 Shared package fetch_pkg SHALL hold NOP_INSTR=32'h0000_0013, RESET_PC default, QDEPTH default, FSM state typedef.
REQ-020 Sub-module fetch_fifo (parameterised width/depth synchronous FIFO, push/pop/flush/full/empty/count) SHALL implement both tag FIFO and data queue.

Verification
REQ-021 Reset release, gnt=1, rvalid 1 cycle after each grant -> IF_ID_pc sequence 0x0,0x4,0x8 on consecutive cycles, first IF_ID_valid 3 cycles after reset falls.
REQ-022 stall=1 for 3 cycles while streaming -> IF/ID held at same pc; imem_req drops after 2 outstanding; after release, next pcs contiguous, none lost.
REQ-023 branch_taken with target 0x100 while 2 fetches in flight -> both responses dropped; next IF_ID_pc = 0x100.
REQ-024 branch_taken and stall same cycle -> redirect wins; IF/ID bubble next cycle; imem_addr=0x100.
REQ-025 flush_IF_ID alone with 1 queued entry at 0x8 -> bubble (instr 0x13, valid 0), then 0x8 delivered next cycle.
REQ-026 reset asserted with 2 in flight, then rvalid pulses -> responses ignored, fetch restarts at RESET_PC.
